// File: rtl/lc3_decode.sv
// LC3 decode stage: waits MEM_LAT edges after a start, latches the instruction word, splits it into fields.
// Optional illegal-opcode detection is enabled by defining LC3_DECODE_ILLEGAL_EN.
module lc3_decode #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        decode_start,
    input  logic [15:0] instr_in,
    output logic        busy,
    output logic        decode_done,
    output logic [15:0] ir_out,
    output logic [3:0]  opCode_out,
    output logic [2:0]  dr_out,
    output logic [2:0]  sr1_out,
    output logic [2:0]  sr2_out,
    output logic        imm_mode,
    output logic [15:0] imm5_sext,
    output logic [15:0] offset6_sext,
    output logic [8:0]  offset9_out,
    output logic [10:0] offset11_out,
    output logic        jsr_mode,
    output logic [2:0]  br_nzp,
    output logic        illegal_out
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t      state;
    logic [3:0]  cnt;
    logic [15:0] ir;

    function automatic logic [15:0] sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

    function automatic logic [15:0] sext6(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction

    // Handshake FSM: count down the memory latency, then capture the word and pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            ir          <= 16'h0000;
            busy        <= 1'b0;
            decode_done <= 1'b0;
        end else begin
            decode_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (decode_start) begin
                        cnt   <= LAT;
                        busy  <= 1'b1;
                        state <= ST_WAIT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    // Starts arriving here are dropped; the capture happens on the 1->0 step.
                    if (cnt == 4'd1) begin
                        ir          <= instr_in;
                        decode_done <= 1'b1;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= 4'd0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ir_out       = ir;
    assign opCode_out   = ir[15:12];
    assign dr_out       = ir[11:9];
    assign sr1_out      = ir[8:6];
    assign sr2_out      = ir[2:0];
    assign imm_mode     = ir[5];
    assign imm5_sext    = sext5(ir[4:0]);
    assign offset6_sext = sext6(ir[5:0]);
    assign offset9_out  = ir[8:0];
    assign offset11_out = ir[10:0];
    assign jsr_mode     = ir[11];
    // Only BR carries a condition mask; an all-zero IR is BR with nzp=000 and never branches.
    assign br_nzp       = (ir[15:12] == 4'b0000) ? ir[11:9] : 3'b000;

`ifdef LC3_DECODE_ILLEGAL_EN
    // 1101 is reserved and 1000 (RTI) is not supported by this core.
    assign illegal_out = (ir[15:12] == 4'b1101) || (ir[15:12] == 4'b1000);
`else
    assign illegal_out = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_decode.sv
// Self-checking bench for lc3_decode: directed and random decodes on a MEM_LAT=1 and a MEM_LAT=3 instance.
module tb_lc3_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start1 = 1'b0;
    logic        start3 = 1'b0;
    logic [15:0] instr = 16'h0000;

    logic        busy1, done1, jsr1, imm1, ill1;
    logic        busy3, done3, jsr3, imm3, ill3;
    logic [15:0] ir1, i5_1, o6_1, ir3, i5_3, o6_3;
    logic [3:0]  op1, op3;
    logic [2:0]  dr1, s1_1, s2_1, nzp1, dr3, s1_3, s2_3, nzp3;
    logic [8:0]  o9_1, o9_3;
    logic [10:0] o11_1, o11_3;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lc3_decode #(.MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .decode_start(start1), .instr_in(instr),
        .busy(busy1), .decode_done(done1), .ir_out(ir1), .opCode_out(op1),
        .dr_out(dr1), .sr1_out(s1_1), .sr2_out(s2_1), .imm_mode(imm1),
        .imm5_sext(i5_1), .offset6_sext(o6_1), .offset9_out(o9_1),
        .offset11_out(o11_1), .jsr_mode(jsr1), .br_nzp(nzp1), .illegal_out(ill1)
    );

    lc3_decode #(.MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .decode_start(start3), .instr_in(instr),
        .busy(busy3), .decode_done(done3), .ir_out(ir3), .opCode_out(op3),
        .dr_out(dr3), .sr1_out(s1_3), .sr2_out(s2_3), .imm_mode(imm3),
        .imm5_sext(i5_3), .offset6_sext(o6_3), .offset9_out(o9_3),
        .offset11_out(o11_3), .jsr_mode(jsr3), .br_nzp(nzp3), .illegal_out(ill3)
    );

    logic [86:0] obs1, obs3;
    assign obs1 = {ir1, op1, dr1, s1_1, s2_1, imm1, i5_1, o6_1, o9_1, o11_1, jsr1, nzp1, ill1};
    assign obs3 = {ir3, op3, dr3, s1_3, s2_3, imm3, i5_3, o6_3, o9_3, o11_3, jsr3, nzp3, ill3};

    // Reference decode computed from the ISA field definitions with integer arithmetic.
    function automatic logic [86:0] model(input logic [15:0] w);
        int v, op, dr, sr1, sr2, imm, i5, o6, o9, o11, jsr, nzp, ill;
        v   = int'(w);
        op  = v / 4096;
        dr  = (v / 512) % 8;
        sr1 = (v / 64) % 8;
        sr2 = v % 8;
        imm = (v / 32) % 2;
        i5  = v % 32;
        if (i5 >= 16) i5 = i5 - 32;
        o6  = v % 64;
        if (o6 >= 32) o6 = o6 - 64;
        o9  = v % 512;
        o11 = v % 2048;
        jsr = (v / 2048) % 2;
        nzp = (op == 0) ? dr : 0;
`ifdef LC3_DECODE_ILLEGAL_EN
        ill = (op == 13 || op == 8) ? 1 : 0;
`else
        ill = 0;
`endif
        return {w, 4'(op), 3'(dr), 3'(sr1), 3'(sr2), 1'(imm), 16'(i5), 16'(o6),
                9'(o9), 11'(o11), 1'(jsr), 3'(nzp), 1'(ill)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [86:0] obs, input logic [86:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full decode on one instance (sel=0: MEM_LAT=1, sel=1: MEM_LAT=3), checking busy, done and fields.
    task automatic run(input bit sel, input logic [15:0] w, input string tag);
        int lat;
        lat   = sel ? 3 : 1;
        instr = w;
        if (sel) start3 = 1'b1; else start1 = 1'b1;
        tick();
        start1 = 1'b0;
        start3 = 1'b0;
        chk({tag, "_busy"}, 87'(sel ? busy3 : busy1), 87'(1));
        for (int i = 1; i < lat; i++) begin
            instr = 16'($urandom);
            tick();
            chk({tag, "_wait_done"}, 87'(sel ? done3 : done1), 87'(0));
        end
        instr = w;
        tick();
        instr = 16'($urandom);
        chk({tag, "_done"}, 87'(sel ? done3 : done1), 87'(1));
        chk({tag, "_idle"}, 87'(sel ? busy3 : busy1), 87'(0));
        chk({tag, "_fields"}, sel ? obs3 : obs1, model(w));
        tick();
        chk({tag, "_done_clr"}, 87'(sel ? done3 : done1), 87'(0));
        chk({tag, "_hold"}, sel ? obs3 : obs1, model(w));
    endtask

    initial begin
        logic [15:0] w;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_fields1", obs1, 87'(0));
        chk("rst_fields3", obs3, 87'(0));
        chk("rst_busy_done", 87'({busy1, done1, busy3, done3}), 87'(0));

        // ADD register form
        run(1'b0, 16'h1283, "add_reg");
        chk("add_reg_ir", 87'(ir1), 87'(16'h1283));
        chk("add_reg_regs", 87'({op1, dr1, s1_1, s2_1, imm1, nzp1}), 87'({4'b0001, 3'd1, 3'd2, 3'd3, 1'b0, 3'b000}));

        // ADD immediate
        run(1'b0, 16'h127F, "add_imm");
        chk("add_imm_f", 87'({imm1, i5_1, dr1, s1_1}), 87'({1'b1, 16'hFFFF, 3'd1, 3'd1}));

        // Branch then load
        run(1'b0, 16'h0405, "br");
        chk("br_f", 87'({nzp1, o9_1}), 87'({3'b010, 9'h005}));
        run(1'b0, 16'h697E, "ldr");
        chk("ldr_f", 87'({op1, nzp1, o6_1}), 87'({4'b0110, 3'b000, 16'hFFFE}));

        // Reserved and RTI opcodes
        run(1'b0, 16'hD000, "rsvd");
        chk("rsvd_op", 87'(op1), 87'(4'b1101));
`ifdef LC3_DECODE_ILLEGAL_EN
        chk("rsvd_ill", 87'(ill1), 87'(1));
`else
        chk("rsvd_ill", 87'(ill1), 87'(0));
`endif
        run(1'b0, 16'h8000, "rti");

        // MEM_LAT=3: second start while busy is ignored, only the word at the capture edge is latched
        instr  = 16'h1111;
        start3 = 1'b1;
        tick();
        chk("l3_busy_k", 87'({busy3, done3}), 87'(2'b10));
        tick();
        start3 = 1'b0;
        instr  = 16'h2222;
        chk("l3_busy_k1", 87'({busy3, done3}), 87'(2'b10));
        tick();
        chk("l3_busy_k2", 87'({busy3, done3}), 87'(2'b10));
        chk("l3_ir_k2", 87'(ir3), 87'(0));
        instr = 16'h3333;
        tick();
        chk("l3_cap", 87'({busy3, done3}), 87'(2'b01));
        chk("l3_fields", obs3, model(16'h3333));
        tick();
        tick();
        tick();
        chk("l3_no_second", 87'({busy3, done3}), 87'(0));

        // Reset in the middle of a wait abandons the capture
        instr  = 16'h5555;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_fields", obs3, 87'(0));
        chk("mid_rst_flags", 87'({busy3, done3}), 87'(0));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_rst_no_done", 87'({busy3, done3}), 87'(0));
        end
        run(1'b1, 16'h1283, "post_rst");

        // Back-to-back: start accepted in the cycle decode_done is high
        instr  = 16'hABCD;
        start1 = 1'b1;
        tick();
        tick();
        chk("b2b_first", 87'({done1, busy1}), 87'(2'b10));
        instr = 16'h0E01;
        tick();
        chk("b2b_accept", 87'({done1, busy1}), 87'(2'b01));
        start1 = 1'b0;
        tick();
        chk("b2b_second", obs1, model(16'h0E01));
        chk("b2b_done", 87'(done1), 87'(1));
        tick();

        // Random instruction words on both latencies
        for (int i = 0; i < 40; i++) begin
            w = 16'($urandom);
            if (i % 10 == 3) w[15:12] = 4'b1101;
            if (i % 10 == 7) w[15:12] = 4'b1000;
            if (i % 10 == 5) w[15:12] = 4'b0000;
            run(i[0], w, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lc3_decode.md
Name: lc3_decode

Overview:
- Decode stage of the multicycle LC3 core. Sits directly downstream of the fetch stage.
- Fetch drives the instruction-memory address. This block waits out the memory read latency, latches the returned word into the instruction register (IR), and splits it into fields.
- The fields feed fetch (opcode, PC offset, branch nzp), the register file and the execute stage.

Parameters:
- MEM_LAT, 1, edges from an accepted start to IR capture (instruction-memory read latency). Legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- decode_start  input  1  one-cycle request; memory address already presented by fetch
- instr_in  input  16  instruction-memory read data
- busy  output  1  high while waiting on memory
- decode_done  output  1  one-cycle pulse; IR and fields valid
- ir_out  output  16  latched instruction word
- opCode_out  output  4  IR[15:12]
- dr_out  output  3  IR[11:9]
- sr1_out  output  3  IR[8:6]
- sr2_out  output  3  IR[2:0]
- imm_mode  output  1  IR[5]
- imm5_sext  output  16  IR[4:0], sign-extended
- offset6_sext  output  16  IR[5:0], sign-extended
- offset9_out  output  9  IR[8:0], raw (fetch sign-extends)
- offset11_out  output  11  IR[10:0], raw
- jsr_mode  output  1  IR[11]
- br_nzp  output  3  IR[11:9] when opcode is 0000, else 000
- illegal_out  output  1  reserved/unsupported opcode flag

Behaviour:
- Reset: rst sampled high at a rising edge sets state IDLE and counter 0.
  - All outputs go to 0: busy, decode_done, ir_out and all fields.
  - Reset takes priority over everything, including mid-WAIT; a pending capture is abandoned.
- FSM has two states, IDLE and WAIT, plus a 4-bit down-counter.
- IDLE:
  - With decode_start=1 at an edge: counter loads MEM_LAT, state goes to WAIT, busy=1.
  - With decode_start=0: remain in IDLE.
- WAIT:
  - Each edge decrements the counter.
  - On the edge where the counter goes from 1 to 0: sample instr_in into IR, update every field output, set decode_done=1, set busy=0, state returns to IDLE.
- Latency: start accepted at edge k → IR capture at edge k+MEM_LAT. decode_done is high for exactly the cycle following that edge.
- decode_done is cleared on the next edge unless a new capture occurs on that edge.
- decode_start while busy=1 is ignored (not queued).
- decode_start while decode_done=1 is accepted (state is already IDLE). Back-to-back throughput: one instruction per MEM_LAT+1 cycles.
- Field outputs are combinational from IR.
  - They hold their value between captures.
  - They change only at a capture edge or at reset.
- Sign extension replicates the top bit of the field: imm5 uses bit 4, offset6 uses bit 5.
- br_nzp is forced to 000 for every non-BR opcode, including while IR=0 after reset. An IR of 0x0000 (BR, nzp=000) therefore never branches.
- illegal_out is valid whenever decode_done is high and holds with the IR.

Optional Feature:
- Macro LC3_DECODE_ILLEGAL_EN.
- When defined: illegal_out = 1 when IR[15:12] is 1101 (reserved) or 1000 (RTI, unsupported); otherwise 0. Field outputs are decoded normally regardless.
- When undefined: illegal_out is tied to 0 and the detection logic is absent.

Test Plan:
- ADD register form, MEM_LAT=1: instr_in=0x1283, start at edge k → at edge k+1:
  - ir_out=0x1283, opCode_out=0001, dr_out=1, sr1_out=2, sr2_out=3, imm_mode=0, br_nzp=000.
  - decode_done high for one cycle only.
- ADD immediate: instr_in=0x127F → imm_mode=1, imm5_sext=0xFFFF, dr_out=1, sr1_out=1.
- Branch and load: instr_in=0x0405 → br_nzp=010, offset9_out=0x005. Then instr_in=0x697E → opCode_out=0110, br_nzp=000, offset6_sext=0xFFFE.
- MEM_LAT=3:
  - Start at edge k; a second start at edge k+1 is ignored. Capture occurs at edge k+3; busy is high k+1..k+3; exactly one decode_done pulse.
  - instr_in changed at edge k+2 is not captured; the value present at edge k+3 is captured.
- Reset mid-WAIT: rst=1 at edge k+1 with MEM_LAT=3 → all outputs 0 and no decode_done. A new start after reset completes normally.
- Illegal opcode: instr_in=0xD000 → illegal_out=1 with LC3_DECODE_ILLEGAL_EN defined, 0 without; opCode_out=1101 in both builds.
